// File: rtl/bit_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bit_scan_pkg                                                 |
// | Description : Shared types and constants for the set-bit scanner family.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package bit_scan_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic int calc_idx_w(input int width);
        return $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsb_priority_enc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lsb_priority_enc                                             |
// | Description : Combinational index of the lowest set bit (0 if none set).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lsb_priority_enc
    import bit_scan_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IDX_W = calc_idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] rem,
    output logic [IDX_W-1:0] index
);

    // Walk from MSB down so the lowest set bit is the final assignment.
    always_comb begin
        index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rem[i]) begin
                index = i[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/set_bit_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : set_bit_scanner                                              |
// | Description : Emits the index of every set bit of a word, LSB first, one   |
// |               beat per cycle. Optional popcount port: BIT_SCAN_COUNT_EN.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module set_bit_scanner
    import bit_scan_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IDX_W = calc_idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             out_empty,
`ifdef BIT_SCAN_COUNT_EN
    output logic [IDX_W:0]   out_count,
`endif
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_rem_dec;
    logic [WIDTH-1:0] w_rem_clr;
    logic [IDX_W-1:0] w_enc_idx;
    logic             w_in_sc;
    logic             w_accept;

    lsb_priority_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .rem   (r_rem),
        .index (w_enc_idx)
    );

    // Modulo arithmetic: at rem==0 the clear result stays 0.
    assign w_rem_dec = r_rem - WIDTH'(1);
    assign w_rem_clr = r_rem & w_rem_dec;
    assign w_in_sc   = (r_state == SCAN);
    assign w_accept  = in_valid && in_ready;

    assign out_index = w_in_sc ? w_enc_idx : '0;
    assign out_last  = w_in_sc && (w_rem_clr == '0);
    assign out_empty = w_in_sc && (r_rem == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_rem_nxt   = in_data;
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    w_rem_nxt = w_rem_clr;
                    if (out_last) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef BIT_SCAN_COUNT_EN
    logic [IDX_W:0] r_count;
    logic [IDX_W:0] w_pop;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + {{IDX_W{1'b0}}, in_data[i]};
        end
    end

    // Captured with the word so every beat of it reports the same count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= w_pop;
        end
    end

    assign out_count = r_count;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
`endif

endmodule
`default_nettype wire

// File: tb/tb_set_bit_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_set_bit_scanner                                           |
// | Description : Directed self-checking bench for set_bit_scanner.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_set_bit_scanner;

    localparam int WIDTH = 32;
    localparam int IDX_W = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic             out_last;
    logic             out_empty;
    logic             busy;
`ifdef BIT_SCAN_COUNT_EN
    logic [IDX_W:0]   out_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    set_bit_scanner #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .out_empty (out_empty),
`ifdef BIT_SCAN_COUNT_EN
        .out_count (out_count),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a word for one edge while the block is idle.
    task automatic send(input logic [WIDTH-1:0] d);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            step();
            t++;
        end
        chk("send_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Check the beat presented now, then take it with out_ready high.
    task automatic beat(input string tag, input int idx, input bit last, input bit empty);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_index"}, {59'd0, out_index}, 64'(idx));
        chk({tag, "_last"},  {63'd0, out_last},  {63'd0, last});
        chk({tag, "_empty"}, {63'd0, out_empty}, {63'd0, empty});
        chk({tag, "_inrdy"}, {63'd0, in_ready},  64'd0);
        chk({tag, "_busy"},  {63'd0, busy},      64'd1);
        out_ready = 1'b1;
        step();
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_ovalid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_inrdy"},  {63'd0, in_ready},  64'd1);
        chk({tag, "_busy"},   {63'd0, busy},      64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #23;
        chk("rst_ovalid", {63'd0, out_valid}, 64'd0);
        chk("rst_index",  {59'd0, out_index}, 64'd0);
        chk("rst_last",   {63'd0, out_last},  64'd0);
        chk("rst_empty",  {63'd0, out_empty}, 64'd0);
        chk("rst_busy",   {63'd0, busy},      64'd0);
`ifdef BIT_SCAN_COUNT_EN
        chk("rst_count",  {58'd0, out_count}, 64'd0);
`endif
        step();
        rst_n = 1'b1;
        step();
        idle_chk("post_rst");

        // All-zero word: one empty/last beat.
        send(32'h0000_0000);
`ifdef BIT_SCAN_COUNT_EN
        chk("zero_count", {58'd0, out_count}, 64'd0);
`endif
        beat("zero", 0, 1'b1, 1'b1);
        idle_chk("zero_done");

        // Sparse word with top bit set.
        send(32'h8000_0011);
`ifdef BIT_SCAN_COUNT_EN
        chk("sparse_count0", {58'd0, out_count}, 64'd3);
`endif
        beat("sparse0", 0, 1'b0, 1'b0);
        beat("sparse4", 4, 1'b0, 1'b0);
`ifdef BIT_SCAN_COUNT_EN
        chk("sparse_count2", {58'd0, out_count}, 64'd3);
`endif
        beat("sparse31", 31, 1'b1, 1'b0);
        idle_chk("sparse_done");

        // Dense word: every index in order.
        send(32'hFFFF_FFFF);
`ifdef BIT_SCAN_COUNT_EN
        chk("full_count", {58'd0, out_count}, 64'd32);
`endif
        for (int i = 0; i < 32; i++) begin
            beat($sformatf("full%0d", i), i, (i == 31), 1'b0);
        end
        idle_chk("full_done");

        // Backpressure: index 1 held across a two-cycle stall.
        send(32'h0000_0006);
        out_ready = 1'b0;
        step();
        chk("stall1_index", {59'd0, out_index}, 64'd1);
        chk("stall1_valid", {63'd0, out_valid}, 64'd1);
        step();
        chk("stall2_index", {59'd0, out_index}, 64'd1);
        chk("stall2_last",  {63'd0, out_last},  64'd0);
        beat("stall_b1", 1, 1'b0, 1'b0);
        beat("stall_b2", 2, 1'b1, 1'b0);
        idle_chk("stall_done");

        // Reset mid-scan after two beats.
        send(32'h0000_00F0);
        beat("abort4", 4, 1'b0, 1'b0);
        beat("abort5", 5, 1'b0, 1'b0);
        chk("abort6_index", {59'd0, out_index}, 64'd6);
        rst_n = 1'b0;
        #1;
        chk("abort_ovalid", {63'd0, out_valid}, 64'd0);
        chk("abort_index",  {59'd0, out_index}, 64'd0);
        chk("abort_last",   {63'd0, out_last},  64'd0);
        chk("abort_busy",   {63'd0, busy},      64'd0);
`ifdef BIT_SCAN_COUNT_EN
        chk("abort_count",  {58'd0, out_count}, 64'd0);
`endif
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            idle_chk($sformatf("abort_after%0d", i));
        end

        // Queued words: second accepted only after an IDLE cycle.
        in_valid = 1'b1;
        in_data  = 32'h0000_0003;
        step();
        in_data  = 32'h0000_0008;
        beat("q_a0", 0, 1'b0, 1'b0);
        beat("q_a1", 1, 1'b1, 1'b0);
        idle_chk("q_gap");
        step();
        in_valid = 1'b0;
        in_data  = '0;
`ifdef BIT_SCAN_COUNT_EN
        chk("q_b_count", {58'd0, out_count}, 64'd1);
`endif
        beat("q_b3", 3, 1'b1, 1'b0);
        idle_chk("q_done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
